// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU priority, round-robin load/muldiv.
// Optional starvation guard enabled by RF_WB_STARVE_GUARD_EN.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_waddr,
  input  logic [31:0] ld_wdata,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [1:0]  grant_src,
  output logic        pipe_stall
);

  localparam logic       PTR_LD  = 1'b0;
  localparam logic       PTR_MD  = 1'b1;
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_LD   = 2'd2;
  localparam logic [1:0] SRC_MD   = 2'd3;

  logic rr_ptr;
  logic ld_sel;
  logic md_sel;
  logic ld_hs;
  logic md_hs;
  logic any_hs;

  // A lone requester wins regardless of the pointer.
  always_comb begin
    ld_sel = ld_valid & (~md_valid | (rr_ptr == PTR_LD));
    md_sel = md_valid & (~ld_valid | (rr_ptr == PTR_MD));
  end

  assign ld_ready = reset_n & ~alu_valid & ld_sel;
  assign md_ready = reset_n & ~alu_valid & md_sel;

  assign ld_hs  = ld_valid & ld_ready;
  assign md_hs  = md_valid & md_ready;
  assign any_hs = ld_hs | md_hs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= PTR_LD;
    end else if (ld_hs) begin
      rr_ptr <= PTR_MD;
    end else if (md_hs) begin
      rr_ptr <= PTR_LD;
    end
  end

  // Address/data hold when nothing is accepted; x0 writes keep we low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
      grant_src <= SRC_NONE;
    end else if (alu_valid) begin
      rf_we     <= (alu_waddr != 5'd0);
      rf_waddr  <= alu_waddr;
      rf_wdata  <= alu_wdata;
      grant_src <= SRC_ALU;
    end else if (ld_hs) begin
      rf_we     <= (ld_waddr != 5'd0);
      rf_waddr  <= ld_waddr;
      rf_wdata  <= ld_wdata;
      grant_src <= SRC_LD;
    end else if (md_hs) begin
      rf_we     <= (md_waddr != 5'd0);
      rf_waddr  <= md_waddr;
      rf_wdata  <= md_wdata;
      grant_src <= SRC_MD;
    end else begin
      rf_we     <= 1'b0;
      grant_src <= SRC_NONE;
    end
  end

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 8'd0;
    end else if (any_hs) begin
      starve_cnt <= 8'd0;
    end else if ((ld_valid | md_valid) && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Stall rises the cycle after saturation, falls after a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else if (any_hs) begin
      stall_q <= 1'b0;
    end else if (starve_cnt == LIMIT) begin
      stall_q <= 1'b1;
    end
  end

  assign pipe_stall = stall_q;
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter.
// Exercises priority, round-robin, x0 writes, starvation and reset.
module tb_rf_wb_arbiter;

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_src;
  logic        pipe_stall;

  int checks;
  int errors;

  rf_wb_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .alu_valid(alu_valid),
    .alu_waddr(alu_waddr),
    .alu_wdata(alu_wdata),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_waddr(ld_waddr),
    .ld_wdata(ld_wdata),
    .md_valid(md_valid),
    .md_ready(md_ready),
    .md_waddr(md_waddr),
    .md_wdata(md_wdata),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .grant_src(grant_src),
    .pipe_stall(pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_src [4];
  logic [4:0]  exp_addr [4];
  logic [31:0] exp_data [4];

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    ld_valid = 1'b1;  ld_waddr = '0;  ld_wdata = '0;
    md_valid = 1'b1;  md_waddr = '0;  md_wdata = '0;
    #2;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_src", 32'(grant_src), 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd0);
    ld_valid = 1'b0;
    md_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Round robin from reset: ld first, then alternate.
    exp_src[0] = 2'd2; exp_addr[0] = 5'd1; exp_data[0] = 32'hA1;
    exp_src[1] = 2'd3; exp_addr[1] = 5'd2; exp_data[1] = 32'hB2;
    exp_src[2] = 2'd2; exp_addr[2] = 5'd3; exp_data[2] = 32'hA3;
    exp_src[3] = 2'd3; exp_addr[3] = 5'd4; exp_data[3] = 32'hB4;
    ld_valid = 1'b1; ld_waddr = 5'd1; ld_wdata = 32'hA1;
    md_valid = 1'b1; md_waddr = 5'd2; md_wdata = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ld_ready%0d", i), 32'(ld_ready),
          32'(exp_src[i] == 2'd2));
      chk($sformatf("rr_md_ready%0d", i), 32'(md_ready),
          32'(exp_src[i] == 2'd3));
      step();
      chk($sformatf("rr_src%0d", i), 32'(grant_src), 32'(exp_src[i]));
      chk($sformatf("rr_addr%0d", i), 32'(rf_waddr), 32'(exp_addr[i]));
      chk($sformatf("rr_data%0d", i), rf_wdata, exp_data[i]);
      chk($sformatf("rr_we%0d", i), 32'(rf_we), 32'd1);
      if (exp_src[i] == 2'd2) begin
        ld_waddr = 5'd3; ld_wdata = 32'hA3;
      end else begin
        md_waddr = 5'd4; md_wdata = 32'hB4;
      end
    end
    ld_valid = 1'b0;
    md_valid = 1'b0;

    // ALU priority over a pending load.
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
    ld_valid = 1'b1; ld_waddr = 5'd7; ld_wdata = 32'h11;
    #1;
    chk("alu_ld_ready", 32'(ld_ready), 32'd0);
    step();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_addr", 32'(rf_waddr), 32'd5);
    chk("alu_data", rf_wdata, 32'hDEADBEEF);
    chk("alu_src", 32'(grant_src), 32'd1);
    alu_valid = 1'b0;
    #1;
    chk("ld_after_alu_ready", 32'(ld_ready), 32'd1);
    step();
    chk("ld_after_alu_src", 32'(grant_src), 32'd2);
    chk("ld_after_alu_addr", 32'(rf_waddr), 32'd7);
    chk("ld_after_alu_data", rf_wdata, 32'h11);
    ld_valid = 1'b0;
    step();
    chk("idle_we", 32'(rf_we), 32'd0);
    chk("idle_src", 32'(grant_src), 32'd0);
    chk("idle_addr_hold", 32'(rf_waddr), 32'd7);
    chk("idle_data_hold", rf_wdata, 32'h11);

    // Write to x0 from mul/div.
    md_valid = 1'b1; md_waddr = 5'd0; md_wdata = 32'h1234;
    #1;
    chk("x0_md_ready", 32'(md_ready), 32'd1);
    step();
    chk("x0_src", 32'(grant_src), 32'd3);
    chk("x0_we", 32'(rf_we), 32'd0);
    md_valid = 1'b0;

    // Starvation under continuous ALU traffic.
    alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h99;
    ld_valid = 1'b1; ld_waddr = 5'd10; ld_wdata = 32'hAA;
    for (int c = 1; c <= 8; c++) step();
    chk("starve_c8_stall", 32'(pipe_stall), 32'd0);
    chk("starve_c8_src", 32'(grant_src), 32'd1);
    step();
    chk("starve_c9_stall", 32'(pipe_stall), 32'(GUARD));
    chk("starve_c9_ld_ready", 32'(ld_ready), 32'd0);
    alu_valid = 1'b0;
    #1;
    chk("starve_ld_ready", 32'(ld_ready), 32'd1);
    step();
    chk("starve_ld_src", 32'(grant_src), 32'd2);
    chk("starve_release", 32'(pipe_stall), 32'd0);
    ld_valid = 1'b0;
    step();

    // Reset right after a load handshake.
    ld_valid = 1'b1; ld_waddr = 5'd12; ld_wdata = 32'hCC;
    step();
    chk("prerst_src", 32'(grant_src), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_src", 32'(grant_src), 32'd0);
    chk("midrst_addr", 32'(rf_waddr), 32'd0);
    chk("midrst_data", rf_wdata, 32'd0);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
    step();
    reset_n = 1'b1;
    md_valid = 1'b1; md_waddr = 5'd13; md_wdata = 32'hDD;
    #1;
    chk("postrst_ld_ready", 32'(ld_ready), 32'd1);
    chk("postrst_md_ready", 32'(md_ready), 32'd0);
    step();
    chk("postrst_src", 32'(grant_src), 32'd2);
    chk("postrst_addr", 32'(rf_waddr), 32'd12);
    ld_valid = 1'b0;
    md_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive denied cycles before a stall is forced (range 2..255).
REQ-002 The module SHALL have port clk, input, 1, system clock, with all state updating on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have ports alu_valid (in, 1), alu_waddr (in, 5) and alu_wdata (in, 32), the ALU writeback request, which has no backpressure.
REQ-005 The module SHALL have ports ld_valid (in, 1), ld_ready (out, 1), ld_waddr (in, 5) and ld_wdata (in, 32), the load-unit valid/ready request.
REQ-006 The module SHALL have ports md_valid (in, 1), md_ready (out, 1), md_waddr (in, 5) and md_wdata (in, 32), the mul/div-unit valid/ready request.
REQ-007 The module SHALL have ports rf_we (out, 1), rf_waddr (out, 5) and rf_wdata (out, 32), driving the register-file write port.
REQ-008 The module SHALL have port grant_src, output, 2, source of the current rf_* write: 0 none, 1 ALU, 2 load, 3 mul/div.
REQ-009 The module SHALL have port pipe_stall, output, 1, a request that the issue pipeline hold alu_valid low.

Function
REQ-010 The ALU SHALL always win arbitration when alu_valid=1, irrespective of pipe_stall.
REQ-011 When alu_valid=0, the arbiter SHALL grant exactly one of ld or md by round-robin; a lone valid requester SHALL be granted immediately.
REQ-012 The round-robin pointer SHALL flip only on a completed ld or md handshake, and SHALL then point to the other unit.
REQ-013 ld_ready and md_ready SHALL be combinational and one-hot-or-zero; a handshake is valid and ready in the same cycle.
REQ-014 Both ld_ready and md_ready SHALL be 0 in any cycle with alu_valid=1.
REQ-015 An accepted request SHALL appear on rf_we/rf_waddr/rf_wdata/grant_src exactly one cycle after acceptance, with registered outputs.
REQ-016 In cycles with no acceptance, rf_we SHALL be 0, grant_src SHALL be 0, and rf_waddr/rf_wdata SHALL hold their last value.
REQ-017 A request to waddr 0 SHALL be accepted (handshake completes, grant_src set) with rf_we=0.
REQ-018 A requester SHALL hold waddr/wdata stable while valid=1 and ready=0; the arbiter SHALL sample them only on acceptance.
REQ-019 Simultaneous same-waddr requests SHALL be serialized in grant order; the arbiter performs no merging or reordering beyond arbitration.
REQ-020 Write throughput SHALL be one write per cycle sustained, with no bubble between back-to-back grants.

Reset
REQ-021 On reset_n=0 the module SHALL immediately drive rf_we=0, rf_waddr=0, rf_wdata=0, grant_src=0 and pipe_stall=0.
REQ-022 On reset_n=0 the round-robin pointer SHALL be set to ld and the starvation counter to 0.
REQ-023 ld_ready and md_ready SHALL be 0 while reset_n=0.
REQ-024 A write registered but not yet presented when reset asserts SHALL be discarded.
REQ-025 The first acceptance SHALL be possible on the first rising clk edge after reset_n rises.

Configuration
REQ-026 The macro RF_WB_STARVE_GUARD_EN SHALL control starvation protection.
REQ-027 With RF_WB_STARVE_GUARD_EN defined, an 8-bit counter SHALL increment each cycle ld_valid or md_valid is 1 with no ld/md handshake, saturating at STARVE_LIMIT.
REQ-028 With RF_WB_STARVE_GUARD_EN defined, the counter SHALL clear on any ld/md handshake.
REQ-029 With RF_WB_STARVE_GUARD_EN defined, pipe_stall SHALL be registered and SHALL assert in the cycle after the counter reaches STARVE_LIMIT.
REQ-030 With RF_WB_STARVE_GUARD_EN defined, pipe_stall SHALL stay high until an ld/md handshake occurs, deasserting the cycle after that handshake.
REQ-031 Without RF_WB_STARVE_GUARD_EN, pipe_stall SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-032 The bench SHALL cover: alu_valid=1, waddr=5, wdata=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_src=1.
REQ-033 The bench SHALL cover: ld and md both valid for 4 cycles with alu_valid=0 and pointer=ld after reset -> grant_src sequence 2,3,2,3, each one cycle after its handshake.
REQ-034 The bench SHALL cover: alu_valid=1 with ld_valid=1 -> ld_ready=0; ALU written; ld granted in the first cycle alu_valid=0.
REQ-035 The bench SHALL cover: md request with waddr=0, wdata=0x1234 -> md_ready=1, then next cycle grant_src=3 and rf_we=0.
REQ-036 The bench SHALL cover, with guard on and STARVE_LIMIT=8: alu_valid=1 continuously and ld_valid=1 -> pipe_stall=1 at cycle 9; after alu_valid drops, ld handshake occurs and pipe_stall=0 the following cycle.
REQ-037 The bench SHALL cover: reset_n asserted one cycle after an ld handshake -> rf_we stays 0, all outputs 0, and pointer=ld after release.
